mil1553_chan_mux: RTL and testbench
===================================

# mil1553_chan_mux

Parametrised N-channel MIL-STD-1553 bus multiplexer that sits between the `uart_1553_core` word streams and N redundant 1553 encoder/decoder channels (bus A/B/...). It routes each outgoing message to the bus chosen at message start. It then holds that bus in a listen window with a response timeout and an end-of-response gap detector, and forwards received words through a small output FIFO. Between transactions it passes unsolicited receive traffic from any bus using fixed priority.

## Interface
Parameters:
- `CHANNELS`, 2, number of 1553 buses (2..8); `CH_W = max(1, clog2(CHANNELS))`
- `RESP_TIMEOUT`, 68, cycles from line release to first rx word before timeout (14 µs response time + 20 µs word at 2 MHz)
- `GAP_CYCLES`, 48, idle cycles after last rx word that close the response
- `GUARD_CYCLES`, 8, bus turnaround cycles before the next message
- `FIFO_DEPTH`, 4, rx output FIFO depth, power of two

Ports:
- `aclk` in 1: the block's only clock
- `arstn` in 1: reset, asynchronous, active-low
- `sel_chan` in CH_W: bus for the next message, sampled in IDLE
- `s_axis_tdata` in 16 / `s_axis_tuser` in 8 / `s_axis_tlast` in 1 / `s_axis_tvalid` in 1 / `s_axis_tready` out 1: tx words from core
- `tx_tdata` out 16·N / `tx_tuser` out 8·N / `tx_tvalid` out N / `tx_tready` in N: per-bus encoder streams
- `tx_active` in N: encoder driving line
- `rx_tdata` in 16·N / `rx_tuser` in 8·N / `rx_tvalid` in N: per-bus decoder word pulses, no backpressure
- `m_axis_tdata` out 16 / `m_axis_tuser` out 8 / `m_axis_tvalid` out 1 / `m_axis_tready` in 1: rx words to core
- `rx_chan` out CH_W: bus of the word at the FIFO head
- `busy` out 1: state ≠ IDLE
- `timeout` out 1: one-cycle pulse on response timeout
- `overflow` out 1: sticky; rx word dropped because the FIFO was full; cleared only by reset
- `stat_timeouts` out 8·N: see Configuration

## Operation
- States: IDLE, TX, DRAIN, LISTEN, GUARD.
- **IDLE**
  - `s_axis_tready` = 0.
  - When `s_axis_tvalid` = 1: latch `cur` = `sel_chan`, clear counters, go to TX.
  - If `sel_chan` ≥ CHANNELS, latch `cur` = 0.
- **TX**
  - `tx_tvalid[cur]` = `s_axis_tvalid`.
  - `s_axis_tready` = `tx_tready[cur]`.
  - `tx_tdata`/`tx_tuser[cur]` pass combinationally; the other channels' data and valid are 0.
  - Handshake with `tlast` = 1 → DRAIN.
- **DRAIN**
  - Minimum 2 cycles.
  - Then wait for `tx_active[cur]` = 0 → LISTEN.
- **LISTEN**
  - Counter increments each cycle.
  - `rx_tvalid[cur]` pushes the word and restarts the counter in gap mode.
  - Before the first word: counter = RESP_TIMEOUT → pulse `timeout`, go to GUARD.
  - After a word: counter = GAP_CYCLES → GUARD.
  - rx on other channels is dropped.
- **GUARD**
  - GUARD_CYCLES cycles → IDLE.
- **Unsolicited rx**
  - In IDLE or GUARD, `rx_tvalid` on any channel is pushed.
  - If several channels are valid in the same cycle, the lowest index wins and the others are dropped (this does not set `overflow`).
- **FIFO**
  - Push when not full; otherwise drop and set `overflow`.
  - Simultaneous push and pop on a full FIFO is permitted.
  - Entry = {channel, tuser, data}.
- **Reset**
  - Asynchronous: state → IDLE, FIFO empty, all outputs 0 (including `tx_tvalid`, `m_axis_tvalid`, `busy`, `overflow`, counters), even mid-message.

## Timing
- IDLE→TX: first `s_axis_tready` one cycle after `tvalid` is seen.
- Tx path: zero latency, combinational.
- Rx path: `rx_tvalid` at cycle n → `m_axis_tvalid` at n+1 when the FIFO was empty.
- `timeout` asserts exactly RESP_TIMEOUT cycles after LISTEN entry.
- GUARD always lasts exactly GUARD_CYCLES.
- `m_axis_*` held stable until `tready`; AXIS rules apply.

## Configuration
- `MIL1553_CHAN_MUX_STATS_EN` defined:
  - Per-channel 8-bit saturating timeout counters on `stat_timeouts[8·i +: 8]`.
  - The counter for `cur` increments with each `timeout` pulse and saturates at 255.
  - Counters are cleared only by reset.
- `MIL1553_CHAN_MUX_STATS_EN` undefined: `stat_timeouts` tied to 0, no counter logic.

## Structure
- Shared package `mil1553_chan_mux_pkg`:
  - state enumeration
  - `CHAN_MAX` = 8
  - rx FIFO entry field offsets
- One sub-module, `mil1553_chan_mux_fifo`: synchronous FIFO parametrised by width and depth, with full, empty and registered output.

## Test plan
- CHANNELS=2, `sel_chan`=1, 2-word message (0x1234, then 0xABCD with `tlast`) → both words appear only on `tx_tdata[31:16]`; `tx_tvalid[0]` stays 0.
- After tx, `tx_active[1]` falls; no rx for 68 cycles → `timeout` pulses on cycle 68; GUARD lasts 8 cycles; `stat_timeouts[15:8]` = 1 with STATS_EN.
- Reply 0x0800 on bus 1 at 30 cycles after release, plus 0x5555 on bus 0 in the same window → only 0x0800 is output, `rx_chan` = 1; GUARD is entered 48 cycles later.
- In IDLE, simultaneous `rx_tvalid` = 2'b11 → one word from channel 0 is output.
- `m_axis_tready` = 0, 5 unsolicited words with FIFO_DEPTH=4 → 4 words retained, `overflow` = 1.
- `arstn` asserted mid-TX → `tx_tvalid` = 0 and `busy` = 0 immediately; after release, a new message on `sel_chan` = 0 proceeds normally.

Source files
------------

// File: rtl/mil1553_chan_mux_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mil1553_chan_mux_pkg : FSM state encoding and rx FIFO entry layout
// Rev 1.0
// ----------------------------------------------------------------------------
package mil1553_chan_mux_pkg;

   localparam int CHAN_MAX = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_TX     = 3'd1;
   localparam logic [2:0] ST_DRAIN  = 3'd2;
   localparam logic [2:0] ST_LISTEN = 3'd3;
   localparam logic [2:0] ST_GUARD  = 3'd4;

   // Rx FIFO entry = {channel, tuser, data}
   localparam int ENT_DATA_LSB = 0;
   localparam int ENT_USER_LSB = 16;
   localparam int ENT_CHAN_LSB = 24;

endpackage
`default_nettype wire

// File: rtl/mil1553_chan_mux_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mil1553_chan_mux_fifo : synchronous FIFO, DEPTH a power of two >= 2
// Rev 1.0
// ----------------------------------------------------------------------------
module mil1553_chan_mux_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/mil1553_chan_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mil1553_chan_mux : N-bus MIL-STD-1553 tx router / rx listen-window muxer
// Option: MIL1553_CHAN_MUX_STATS_EN adds per-bus saturating timeout counters
// Rev 1.0
// ----------------------------------------------------------------------------
module mil1553_chan_mux
   import mil1553_chan_mux_pkg::*;
#(
   parameter int CHANNELS     = 2,
   parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int RESP_TIMEOUT = 68,
   parameter int GAP_CYCLES   = 48,
   parameter int GUARD_CYCLES = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  aclk,
   input  logic                  arstn,
   input  logic [CH_W-1:0]       sel_chan,
   input  logic [15:0]           s_axis_tdata,
   input  logic [7:0]            s_axis_tuser,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [16*CHANNELS-1:0] tx_tdata,
   output logic [8*CHANNELS-1:0] tx_tuser,
   output logic [CHANNELS-1:0]   tx_tvalid,
   input  logic [CHANNELS-1:0]   tx_tready,
   input  logic [CHANNELS-1:0]   tx_active,
   input  logic [16*CHANNELS-1:0] rx_tdata,
   input  logic [8*CHANNELS-1:0] rx_tuser,
   input  logic [CHANNELS-1:0]   rx_tvalid,
   output logic [15:0]           m_axis_tdata,
   output logic [7:0]            m_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [CH_W-1:0]       rx_chan,
   output logic                  busy,
   output logic                  timeout,
   output logic                  overflow,
   output logic [8*CHANNELS-1:0] stat_timeouts
);

   localparam int ENT_W   = ENT_CHAN_LSB + CH_W;
   localparam int CNT_MAX = (RESP_TIMEOUT > GAP_CYCLES)
                          ? ((RESP_TIMEOUT > GUARD_CYCLES) ? RESP_TIMEOUT : GUARD_CYCLES)
                          : ((GAP_CYCLES > GUARD_CYCLES) ? GAP_CYCLES : GUARD_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [2:0]       state_q, state_d;
   logic [CH_W-1:0]  cur_q, cur_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             got_q, got_d;
   logic             overflow_q, overflow_d;

   logic             rx_hit;
   logic [CH_W-1:0]  rx_sel;
   logic [ENT_W-1:0] push_ent;
   logic [ENT_W-1:0] head_ent;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             resp_timeout;

   assign resp_timeout = (state_q == ST_LISTEN) && !got_q &&
                         (cnt_q == CNT_W'(RESP_TIMEOUT));

   // Listen window accepts only the addressed bus; idle/guard take the lowest index.
   always_comb begin
      rx_sel = cur_q;
      rx_hit = 1'b0;
      if (state_q == ST_LISTEN) begin
         rx_hit = rx_tvalid[cur_q];
      end else if (state_q == ST_IDLE || state_q == ST_GUARD) begin
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rx_tvalid[i]) begin
               rx_sel = CH_W'(i);
               rx_hit = 1'b1;
            end
         end
      end
   end

   assign push_ent = {rx_sel, rx_tuser[8*rx_sel +: 8], rx_tdata[16*rx_sel +: 16]};

   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      cnt_d         = cnt_q;
      got_d         = got_q;
      s_axis_tready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid) begin
               cur_d   = (int'(sel_chan) < CHANNELS) ? sel_chan : '0;
               cnt_d   = '0;
               got_d   = 1'b0;
               state_d = ST_TX;
            end
         end
         ST_TX: begin
            s_axis_tready = tx_tready[cur_q];
            if (s_axis_tvalid && tx_tready[cur_q] && s_axis_tlast) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               cnt_d = CNT_W'(1);
            end else if (!tx_active[cur_q]) begin
               cnt_d   = '0;
               state_d = ST_LISTEN;
            end
         end
         ST_LISTEN: begin
            cnt_d = cnt_q + 1'b1;
            if (resp_timeout) begin
               cnt_d   = '0;
               state_d = ST_GUARD;
            end else if (rx_hit) begin
               // Word cycle is gap count 0, so the next cycle reads 1.
               got_d = 1'b1;
               cnt_d = CNT_W'(1);
            end else if (got_q && cnt_q == CNT_W'(GAP_CYCLES)) begin
               cnt_d   = '0;
               state_d = ST_GUARD;
            end
         end
         ST_GUARD: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      tx_tdata  = '0;
      tx_tuser  = '0;
      tx_tvalid = '0;
      if (state_q == ST_TX) begin
         tx_tdata[16*cur_q +: 16] = s_axis_tdata;
         tx_tuser[8*cur_q +: 8]   = s_axis_tuser;
         tx_tvalid[cur_q]         = s_axis_tvalid;
      end
   end

   assign pop        = !fifo_empty && m_axis_tready;
   assign overflow_d = overflow_q | (rx_hit && fifo_full && !pop);

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q    <= ST_IDLE;
         cur_q      <= '0;
         cnt_q      <= '0;
         got_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         cnt_q      <= cnt_d;
         got_q      <= got_d;
         overflow_q <= overflow_d;
      end
   end

   mil1553_chan_mux_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk     (aclk),
      .rst_n   (arstn),
      .wr_en   (rx_hit),
      .wr_data (push_ent),
      .rd_en   (pop),
      .rd_data (head_ent),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = head_ent[ENT_DATA_LSB +: 16];
   assign m_axis_tuser  = head_ent[ENT_USER_LSB +: 8];
   assign rx_chan       = head_ent[ENT_CHAN_LSB +: CH_W];
   assign busy          = (state_q != ST_IDLE);
   assign timeout       = resp_timeout;
   assign overflow      = overflow_q;

`ifdef MIL1553_CHAN_MUX_STATS_EN
   logic [7:0] stat_q [CHANNELS];
   logic [7:0] stat_d [CHANNELS];

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         stat_d[i] = stat_q[i];
         if (resp_timeout && cur_q == CH_W'(i) && stat_q[i] != 8'hFF) begin
            stat_d[i] = stat_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         for (int i = 0; i < CHANNELS; i++) begin
            stat_q[i] <= '0;
         end
      end else begin
         stat_q <= stat_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_stat_out
      assign stat_timeouts[8*g +: 8] = stat_q[g];
   end
`else
   assign stat_timeouts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mil1553_chan_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mil1553_chan_mux : directed self-checking bench, CHANNELS=2 defaults
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mil1553_chan_mux;

   localparam int CHANNELS     = 2;
   localparam int CH_W         = 1;
   localparam int RESP_TIMEOUT = 68;
   localparam int GAP_CYCLES   = 48;
   localparam int GUARD_CYCLES = 8;
   localparam int FIFO_DEPTH   = 4;

`ifdef MIL1553_CHAN_MUX_STATS_EN
   localparam logic [15:0] STAT_AFTER_TO = 16'h0100;
`else
   localparam logic [15:0] STAT_AFTER_TO = 16'h0000;
`endif

   logic                  aclk = 1'b0;
   logic                  arstn = 1'b0;
   logic [CH_W-1:0]       sel_chan;
   logic [15:0]           s_axis_tdata;
   logic [7:0]            s_axis_tuser;
   logic                  s_axis_tlast;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic [16*CHANNELS-1:0] tx_tdata;
   logic [8*CHANNELS-1:0] tx_tuser;
   logic [CHANNELS-1:0]   tx_tvalid;
   logic [CHANNELS-1:0]   tx_tready;
   logic [CHANNELS-1:0]   tx_active;
   logic [16*CHANNELS-1:0] rx_tdata;
   logic [8*CHANNELS-1:0] rx_tuser;
   logic [CHANNELS-1:0]   rx_tvalid;
   logic [15:0]           m_axis_tdata;
   logic [7:0]            m_axis_tuser;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic [CH_W-1:0]       rx_chan;
   logic                  busy;
   logic                  timeout;
   logic                  overflow;
   logic [8*CHANNELS-1:0] stat_timeouts;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   lat;
   int   gcnt;
   logic seen;
   logic early_to;

   always #5 aclk = ~aclk;

   mil1553_chan_mux #(
      .CHANNELS     (CHANNELS),
      .CH_W         (CH_W),
      .RESP_TIMEOUT (RESP_TIMEOUT),
      .GAP_CYCLES   (GAP_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES),
      .FIFO_DEPTH   (FIFO_DEPTH)
   ) dut (
      .aclk          (aclk),
      .arstn         (arstn),
      .sel_chan      (sel_chan),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .tx_tdata      (tx_tdata),
      .tx_tuser      (tx_tuser),
      .tx_tvalid     (tx_tvalid),
      .tx_tready     (tx_tready),
      .tx_active     (tx_active),
      .rx_tdata      (rx_tdata),
      .rx_tuser      (rx_tuser),
      .rx_tvalid     (rx_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .rx_chan       (rx_chan),
      .busy          (busy),
      .timeout       (timeout),
      .overflow      (overflow),
      .stat_timeouts (stat_timeouts)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      sel_chan      = '0;
      s_axis_tdata  = '0;
      s_axis_tuser  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;
      tx_tready     = 2'b11;
      tx_active     = 2'b00;
      rx_tdata      = '0;
      rx_tuser      = '0;
      rx_tvalid     = 2'b00;
      m_axis_tready = 1'b0;

      repeat (3) tick();
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_m_valid",  32'(m_axis_tvalid), 32'd0);
      check("rst_tx_valid", 32'(tx_tvalid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_s_ready",  32'(s_axis_tready), 32'd0);
      check("rst_stats",    32'(stat_timeouts), 32'd0);
      arstn = 1'b1;
      tick();

      // Two-word message to bus 1, then no reply -> timeout.
      tx_active     = 2'b10;
      sel_chan      = 1'b1;
      s_axis_tdata  = 16'h1234;
      s_axis_tuser  = 8'h11;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      #1;
      check("idle_s_ready",  32'(s_axis_tready), 32'd0);
      check("idle_tx_valid", 32'(tx_tvalid), 32'd0);
      tick();
      check("tx1_valid", 32'(tx_tvalid), 32'h2);
      check("tx1_data",  32'(tx_tdata), 32'h1234_0000);
      check("tx1_user",  32'(tx_tuser), 32'h0000_1100);
      check("tx1_ready", 32'(s_axis_tready), 32'd1);
      tick();
      s_axis_tdata = 16'hABCD;
      s_axis_tuser = 8'h22;
      s_axis_tlast = 1'b1;
      #1;
      check("tx2_data",  32'(tx_tdata), 32'hABCD_0000);
      check("tx2_valid", 32'(tx_tvalid), 32'h2);
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      #1;
      check("drain_busy",     32'(busy), 32'd1);
      check("drain_tx_valid", 32'(tx_tvalid), 32'd0);
      repeat (3) tick();
      tx_active = 2'b00;
      lat  = 0;
      seen = 1'b0;
      for (int k = 1; k <= 200 && !seen; k++) begin
         tick();
         if (timeout) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      // One cycle to enter LISTEN, then RESP_TIMEOUT cycles.
      check("timeout_latency", 32'(lat), 32'(RESP_TIMEOUT + 1));
      tick();
      check("timeout_one_cycle", 32'(timeout), 32'd0);
      gcnt = 0;
      for (int k = 0; k < 50 && busy; k++) begin
         gcnt++;
         tick();
      end
      check("guard_len", 32'(gcnt), 32'(GUARD_CYCLES));
      check("stats_after_to", 32'(stat_timeouts), 32'(STAT_AFTER_TO));

      // Reply on bus 1 at LISTEN count 30, foreign word on bus 0 in the same cycle.
      tx_active     = 2'b10;
      sel_chan      = 1'b1;
      s_axis_tdata  = 16'h0F0F;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      tick();
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (2) tick();
      tx_active = 2'b00;
      early_to  = 1'b0;
      for (int k = 0; k < 31; k++) begin
         tick();
         if (timeout) early_to = 1'b1;
      end
      rx_tvalid = 2'b11;
      rx_tdata  = 32'h0800_5555;
      rx_tuser  = 16'h2120;
      tick();
      rx_tvalid = 2'b00;
      check("reply_no_timeout", 32'(early_to), 32'd0);
      check("reply_valid", 32'(m_axis_tvalid), 32'd1);
      check("reply_data",  32'(m_axis_tdata), 32'h0800);
      check("reply_user",  32'(m_axis_tuser), 32'h21);
      check("reply_chan",  32'(rx_chan), 32'd1);
      gcnt = 0;
      for (int k = 0; k < 200 && busy; k++) begin
         gcnt++;
         tick();
      end
      check("gap_plus_guard", 32'(gcnt), 32'(GAP_CYCLES + GUARD_CYCLES));
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      check("reply_single_word", 32'(m_axis_tvalid), 32'd0);
      check("reply_no_overflow", 32'(overflow), 32'd0);
      check("stats_after_reply", 32'(stat_timeouts), 32'(STAT_AFTER_TO));

      // Idle: both buses at once, bus 0 wins.
      rx_tvalid = 2'b11;
      rx_tdata  = 32'h2222_1111;
      rx_tuser  = 16'h0201;
      tick();
      rx_tvalid = 2'b00;
      check("prio_valid", 32'(m_axis_tvalid), 32'd1);
      check("prio_data",  32'(m_axis_tdata), 32'h1111);
      check("prio_user",  32'(m_axis_tuser), 32'h01);
      check("prio_chan",  32'(rx_chan), 32'd0);
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      check("prio_one_word", 32'(m_axis_tvalid), 32'd0);
      check("prio_no_overflow", 32'(overflow), 32'd0);

      // Five unsolicited words into a depth-4 FIFO with the sink stalled.
      for (int i = 0; i < 5; i++) begin
         rx_tvalid = (i % 2 == 1) ? 2'b10 : 2'b01;
         rx_tdata  = {16'(16'hA000 + i), 16'(16'hA000 + i)};
         rx_tuser  = {8'(i), 8'(i)};
         tick();
         if (i == 3) check("fifo_full_no_ovf", 32'(overflow), 32'd0);
      end
      rx_tvalid = 2'b00;
      check("fifo_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("fifo_pop_valid", 32'(m_axis_tvalid), 32'd1);
         check("fifo_pop_data",  32'(m_axis_tdata), 32'(16'hA000 + i));
         check("fifo_pop_chan",  32'(rx_chan), 32'(i % 2));
         m_axis_tready = 1'b1;
         tick();
         m_axis_tready = 1'b0;
      end
      check("fifo_drained", 32'(m_axis_tvalid), 32'd0);
      check("overflow_sticky", 32'(overflow), 32'd1);

      // Reset mid-TX, then a normal message on bus 0.
      tx_active     = 2'b01;
      sel_chan      = 1'b0;
      s_axis_tdata  = 16'h0042;
      s_axis_tuser  = 8'h33;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      tick();
      check("mid_tx_valid", 32'(tx_tvalid), 32'h1);
      check("mid_tx_data",  32'(tx_tdata), 32'h0000_0042);
      #2;
      arstn = 1'b0;
      #1;
      check("arst_tx_valid", 32'(tx_tvalid), 32'd0);
      check("arst_busy",     32'(busy), 32'd0);
      check("arst_overflow", 32'(overflow), 32'd0);
      check("arst_stats",    32'(stat_timeouts), 32'd0);
      s_axis_tvalid = 1'b0;
      tx_active     = 2'b00;
      repeat (2) tick();
      arstn = 1'b1;
      tick();
      s_axis_tdata  = 16'h00C3;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      tick();
      check("post_rst_valid", 32'(tx_tvalid), 32'h1);
      check("post_rst_data",  32'(tx_tdata), 32'h0000_00C3);
      check("post_rst_ready", 32'(s_axis_tready), 32'd1);
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (4) tick();
      rx_tvalid = 2'b01;
      rx_tdata  = 32'h0000_0777;
      rx_tuser  = 16'h0007;
      tick();
      rx_tvalid = 2'b00;
      check("post_rst_rx_data", 32'(m_axis_tdata), 32'h0777);
      check("post_rst_rx_chan", 32'(rx_chan), 32'd0);
      for (int k = 0; k < 200 && busy; k++) begin
         tick();
      end
      check("post_rst_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
